// File: rtl/sync_fifo_thr.sv
// Single-clock FWFT FIFO with registered occupancy, programmable almost-full/empty
// thresholds and synchronous flush. Define SYNC_FIFO_THR_ERR_FLAG_EN for sticky overflow/underflow flags.
module sync_fifo_thr #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 32,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int ADDR_WIDTH    = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_empty_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   count_o
`ifdef SYNC_FIFO_THR_ERR_FLAG_EN
  ,
  input  logic                  err_clr_i,
  output logic                  overflow_o,
  output logic                  underflow_o
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_aempty;
  logic                  r_afull;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Valid/ready: a transfer happens on a cycle where valid is high and the
  // matching ready (registered ~full / ~empty) is high; otherwise the request is dropped.
  assign w_wr_hs = wr_valid_i & ~r_full;
  assign w_rd_hs = rd_valid_i & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_hs && !w_rd_hs) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_rd_hs && !w_wr_hs) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr_hs) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_hs) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count  <= w_count_nxt;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == DEPTH_C);
      r_aempty <= (w_count_nxt <= AEMPTY_C);
      r_afull  <= (w_count_nxt >= AFULL_C);
    end
  end

  // Storage is never cleared; a flushed or reset cycle simply does not write.
  always_ff @(posedge clk) begin
    if (w_wr_hs && !flush_i && !rst) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_i;
    end
  end

  assign data_o         = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign wr_ready_o     = ~r_full;
  assign rd_ready_o     = ~r_empty;
  assign empty_o        = r_empty;
  assign full_o         = r_full;
  assign almost_empty_o = r_aempty;
  assign almost_full_o  = r_afull;
  assign count_o        = r_count;

`ifdef SYNC_FIFO_THR_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;

  // A set condition beats a clear in the same cycle; flush leaves the flags alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_valid_i && r_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr_i) begin
        r_overflow <= 1'b0;
      end
      if (rd_valid_i && r_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Bench for sync_fifo_thr (depth 8, afull 6, aempty 1): directed scenarios plus
// random traffic, checked against a queue-based occupancy model.
module tb_sync_fifo_thr;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic [DW-1:0] data_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [DW-1:0] data_o;
  logic          rd_valid_i;
  logic          rd_ready_o;
  logic          empty_o;
  logic          full_o;
  logic          almost_empty_o;
  logic          almost_full_o;
  logic [3:0]    count_o;
  logic          err_clr_i;
  logic          overflow_o;
  logic          underflow_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];
  logic          mdl_ovf = 1'b0;
  logic          mdl_unf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_thr #(
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (DEPTH),
    .AFULL_THRESH (AF),
    .AEMPTY_THRESH(AE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush_i),
    .data_i        (data_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .data_o        (data_o),
    .rd_valid_i    (rd_valid_i),
    .rd_ready_o    (rd_ready_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_empty_o(almost_empty_o),
    .almost_full_o (almost_full_o),
    .count_o       (count_o)
`ifdef SYNC_FIFO_THR_ERR_FLAG_EN
    ,
    .err_clr_i     (err_clr_i),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
`endif
  );

`ifndef SYNC_FIFO_THR_ERR_FLAG_EN
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = exp_q.size();
    check("count_o", 32'(count_o), 32'(sz));
    check("empty_o", 32'(empty_o), 32'(sz == 0));
    check("full_o", 32'(full_o), 32'(sz == DEPTH));
    check("almost_empty_o", 32'(almost_empty_o), 32'(sz <= AE));
    check("almost_full_o", 32'(almost_full_o), 32'(sz >= AF));
    check("wr_ready_o", 32'(wr_ready_o), 32'(sz != DEPTH));
    check("rd_ready_o", 32'(rd_ready_o), 32'(sz != 0));
`ifdef SYNC_FIFO_THR_ERR_FLAG_EN
    check("overflow_o", 32'(overflow_o), 32'(mdl_ovf));
    check("underflow_o", 32'(underflow_o), 32'(mdl_unf));
`endif
  endtask

  // One clock: drive, check the FWFT head before the edge, advance the model, check state after.
  task automatic step(input logic wv, input logic [DW-1:0] d, input logic rv,
                      input logic fl, input logic rs, input logic clr);
    int   sz;
    logic wr_ok;
    logic rd_ok;
    wr_valid_i = wv;
    data_i     = d;
    rd_valid_i = rv;
    flush_i    = fl;
    rst        = rs;
    err_clr_i  = clr;
    #1;
    sz = exp_q.size();
    if (sz != 0) check("data_o", 32'(data_o), 32'(exp_q[0]));
    wr_ok = wv && (sz < DEPTH);
    rd_ok = rv && (sz > 0);
    if (rs) begin
      mdl_ovf = 1'b0;
      mdl_unf = 1'b0;
    end else begin
      if (wv && sz == DEPTH) mdl_ovf = 1'b1;
      else if (clr)          mdl_ovf = 1'b0;
      if (rv && sz == 0)     mdl_unf = 1'b1;
      else if (clr)          mdl_unf = 1'b0;
    end
    @(posedge clk);
    if (rs || fl) begin
      exp_q.delete();
    end else begin
      if (rd_ok) void'(exp_q.pop_front());
      if (wr_ok) exp_q.push_back(d);
    end
    #1;
    check_state();
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; data_i = '0;
    wr_valid_i = 1'b0; rd_valid_i = 1'b0; err_clr_i = 1'b0;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Fill and drain
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    for (int i = 0; i < 8; i++) pop();
    idle();

    // Full boundary: writes while full are dropped
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    for (int i = 0; i < 3; i++) push(8'hAA);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Simultaneous read+write at full, then at count 7
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    check("head_after_full_rdwr", 32'(data_o), 32'h11);
    step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) pop();

    // Empty with read+write: only the write lands
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    check("head_after_empty_rdwr", 32'(data_o), 32'h3C);
    idle();
    pop();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Pointer wrap with interleaved traffic
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h40 + i));
      pop();
    end

    // Flush at count 5 together with a write
    for (int i = 0; i < 5; i++) push(8'(8'h80 + i));
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // Reset mid-fill
    for (int i = 0; i < 3; i++) push(8'(8'h90 + i));
    step(1'b1, 8'hEF, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 127) == 0),
           1'($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
